lfsr_rng_arbiter: RTL and testbench
===================================

// Module: lfsr_rng_arbiter
// PURPOSE
// Shares one 4-bit Fibonacci LFSR (poly 1+x+x^4) between N_REQ requesters.
// Round-robin arbitration picks one requester at a time. The block then
// steps the LFSR WIDTH times and serially collects output bit lfsr[0] into
// a WIDTH-bit word. The word is returned over a valid/ready response channel.
// A seed port reloads the LFSR; this is the only path software uses to
// configure the generator.
// PARAMETERS
// N_REQ     4        number of requesters, 2..8
// WIDTH     4        bits per response word, 1..16 (= LFSR steps per word)
// SEED_RST  4'b0110  LFSR value after reset and substitute for a zero seed
// PORTS
// clk        in   1               clock, all logic on rising edge
// rst        in   1               synchronous reset, active-high
// req        in   N_REQ           level request per requester
// gnt        out  N_REQ           one-hot grant, held from grant to response accept
// rsp_valid  out  1               response word valid
// rsp_ready  in   1               response consumer ready
// rsp_id     out  $clog2(N_REQ)   index of granted requester
// rsp_data   out  WIDTH           random word
// seed_wr    in   1               load seed request
// seed       in   4               seed value
// seed_ack   out  1               one-cycle pulse: seed loaded
// lfsr_state out  4               current LFSR register (debug/observe)
// BEHAVIOUR
// - LFSR step: s <= {s[3]^s[0], s[3:1]}. Period 15. State 0000 never held.
// - Reset, sampled on clk when rst=1:
//   - s = SEED_RST, FSM = IDLE, rr_ptr = 0.
//   - gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, seed_ack = 0.
//   - Reset mid-SHIFT or mid-RESP aborts the word. No response is issued.
// - FSM IDLE:
//   - seed_wr=1 has priority over req. s <= (seed==0 ? SEED_RST : seed).
//     seed_ack=1 next cycle. Stay IDLE.
//   - Otherwise, if |req: grant first asserted req at or after rr_ptr,
//     wrapping around. gnt/rsp_id register next cycle. cnt <= 0. Go to SHIFT.
//   - seed_wr outside IDLE is ignored: no load, no ack. The source must
//     retry until it sees seed_ack.
// - FSM SHIFT, one cycle per bit:
//   - rsp_data[cnt] <= s[0]; s steps; cnt++.
//   - After the WIDTH-th bit, go to RESP with rsp_valid=1.
//   - The LFSR steps only in SHIFT.
// - FSM RESP:
//   - rsp_valid, rsp_id, rsp_data and gnt held stable until rsp_ready=1.
//   - On handshake: rsp_valid=0, gnt=0, rr_ptr <= granted+1 (mod N_REQ),
//     go to IDLE.
// - Latency: req seen in IDLE at edge t gives gnt at t+1 and rsp_valid at
//   t+1+WIDTH. Minimum per-word period is WIDTH+2 cycles.
// - req changes after grant do not affect the word in flight. A requester
//   still asserting req after its handshake gets a new request, served in
//   round-robin order.
// - rsp_data bits not yet written in a word keep their previous value.
//   Only RESP contents are defined.
// TESTING
// - Reset, then idle 5 cycles -> lfsr_state=0110, all outputs 0, no steps.
// - req=0001, rsp_ready=1 -> gnt=0001 next cycle.
//   - rsp_valid 4 cycles later with rsp_data=4'b0110, rsp_id=0.
//   - Second word = 4'b0010.
// - req=1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0.
//   - gnt one-hot throughout, back-to-back period 6 cycles.
// - rsp_ready=0 for 10 cycles in RESP -> rsp_valid/data/id/gnt stable.
//   - lfsr_state frozen; word completes on the rsp_ready=1 edge.
// - seed_wr with seed=0000 in IDLE -> seed_ack pulse, lfsr_state=0110.
//   - seed=1001 gives lfsr_state=1001.
//   - seed_wr during SHIFT -> no ack, no change.
// - rst=1 mid-SHIFT -> next cycle gnt=0, rsp_valid=0, lfsr_state=0110, IDLE.

Source files
------------

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter sharing one 4-bit Fibonacci LFSR (1+x+x^4) among requesters;
// each grant serially collects WIDTH LFSR output bits into a valid/ready response word.
module lfsr_rng_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 4,
    parameter logic [3:0]  SEED_RST = 4'b0110
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic                     seed_wr,
    input  logic [3:0]               seed,
    output logic                     seed_ack,
    output logic [3:0]               lfsr_state
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [3:0]         lfsr_n;
    logic [N_REQ-1:0]   gnt_n;
    logic               rsp_valid_n;
    logic [ID_W-1:0]    rsp_id_n;
    logic [WIDTH-1:0]   rsp_data_n;
    logic               seed_ack_n;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    pick_off;
    logic               pick_hit;
    logic [ID_W:0]      pick_sum;
    logic [ID_W-1:0]    pick_idx;
    logic [ID_W:0]      nxt_sum;
    logic [ID_W-1:0]    nxt_ptr;

    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        return {s[3] ^ s[0], s[3:1]};
    endfunction

    // Rotate requests so bit 0 is the rr_ptr slot, then take the lowest set bit.
    assign req_dbl = {req, req} >> rr_ptr;
    assign req_rot = req_dbl[N_REQ-1:0];

    always_comb begin
        pick_off = '0;
        pick_hit = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = ID_W'(k);
                pick_hit = 1'b1;
            end
        end
    end

    assign pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    assign pick_idx = (pick_sum >= (ID_W+1)'(N_REQ)) ?
                      ID_W'(pick_sum - (ID_W+1)'(N_REQ)) : ID_W'(pick_sum);

    assign nxt_sum = {1'b0, rsp_id} + (ID_W+1)'(1);
    assign nxt_ptr = (nxt_sum == (ID_W+1)'(N_REQ)) ? '0 : ID_W'(nxt_sum);

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        cnt_n       = cnt;
        lfsr_n      = lfsr_state;
        gnt_n       = gnt;
        rsp_valid_n = rsp_valid;
        rsp_id_n    = rsp_id;
        rsp_data_n  = rsp_data;
        seed_ack_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (seed_wr) begin
                    lfsr_n     = (seed == 4'b0000) ? SEED_RST : seed;
                    seed_ack_n = 1'b1;
                end else if (pick_hit) begin
                    gnt_n    = N_REQ'(1) << pick_idx;
                    rsp_id_n = pick_idx;
                    cnt_n    = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                rsp_data_n[cnt] = lfsr_state[0];
                lfsr_n          = lfsr_step(lfsr_state);
                cnt_n           = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    gnt_n       = '0;
                    rr_ptr_n    = nxt_ptr;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            lfsr_state <= SEED_RST;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            seed_ack   <= 1'b0;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            cnt        <= cnt_n;
            lfsr_state <= lfsr_n;
            gnt        <= gnt_n;
            rsp_valid  <= rsp_valid_n;
            rsp_id     <= rsp_id_n;
            rsp_data   <= rsp_data_n;
            seed_ack   <= seed_ack_n;
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Self-checking bench for lfsr_rng_arbiter: expected words queued at stimulus time,
// popped and compared when the response channel shows valid.
`timescale 1ns/1ps
module tb_lfsr_rng_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             seed_wr;
    logic [3:0]       seed;
    logic             seed_ack;
    logic [3:0]       lfsr_state;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] m_s;
    int         exp_ptr;

    lfsr_rng_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .SEED_RST(4'b0110)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .seed_wr    (seed_wr),
        .seed       (seed),
        .seed_ack   (seed_ack),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    // Reference generator: one word = WIDTH output bits, LSB first.
    task automatic model_word(output logic [3:0] w);
        for (int i = 0; i < WIDTH; i++) begin
            w[i] = m_s[0];
            m_s  = {m_s[3] ^ m_s[0], m_s[3:1]};
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        m_s     = 4'b0110;
        exp_ptr = 0;
    endtask

    task automatic test_reset();
        req = '0; rsp_ready = 1'b0; seed_wr = 1'b0; seed = '0;
        do_reset();
        repeat (5) @(negedge clk);
        vectors++;
        if (lfsr_state !== 4'b0110) begin miscompares++; $display("FAIL reset_lfsr: got %b expected 0110", lfsr_state); end
        vectors++;
        if ({gnt, rsp_valid, rsp_id, rsp_data, seed_ack} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt=%b valid=%b id=%0d data=%b ack=%b expected all 0",
                     gnt, rsp_valid, rsp_id, rsp_data, seed_ack);
        end
    endtask

    task automatic test_single();
        exp_t       e;
        int         n;
        logic [3:0] w;
        sb.push_back('{id: 2'd0, data: 4'b0110});
        sb.push_back('{id: 2'd0, data: 4'b0010});
        model_word(w);
        model_word(w);
        req = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (gnt !== 4'b0001) begin miscompares++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        for (int word = 0; word < 2; word++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
            vectors++;
            if (word == 0 && n != WIDTH) begin miscompares++; $display("FAIL single_latency: got %0d cycles expected %0d", n, WIDTH); end
            if (word == 1 && rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_timeout: got valid=%b expected 1", rsp_valid); end
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            vectors++;
            if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
                miscompares++;
                $display("FAIL single_word%0d: got id=%0d data=%b expected id=%0d data=%b", word, rsp_id, rsp_data, e.id, e.data);
            end
            if (word == 1) req = '0;
            @(negedge clk);
        end
        @(negedge clk);
        vectors++;
        if ({gnt, rsp_valid} !== '0) begin miscompares++; $display("FAIL single_release: got gnt=%b valid=%b expected 0", gnt, rsp_valid); end
        vectors++;
        if (lfsr_state !== m_s) begin miscompares++; $display("FAIL single_lfsr: got %b expected %b", lfsr_state, m_s); end
        exp_ptr = 1;
    endtask

    task automatic test_round_robin();
        exp_t       e;
        logic [3:0] w;
        int         got, cyc, last;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            model_word(w);
            sb.push_back('{id: 2'(exp_ptr), data: w});
            exp_ptr = (exp_ptr + 1) % N_REQ;
        end
        req = 4'b1111; rsp_ready = 1'b1;
        got = 0; cyc = 0; last = 0;
        while (got < 5 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            vectors++;
            if (!$onehot0(gnt)) begin miscompares++; $display("FAIL rr_onehot: got gnt=%b expected one-hot or 0", gnt); end
            if (rsp_valid === 1'b1) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                vectors++;
                if ({rsp_id, rsp_data, gnt} !== {e.id, e.data, 4'(4'b0001 << e.id)}) begin
                    miscompares++;
                    $display("FAIL rr_word%0d: got id=%0d data=%b gnt=%b expected id=%0d data=%b", got, rsp_id, rsp_data, gnt, e.id, e.data);
                end
                if (got > 0) begin
                    vectors++;
                    if (cyc - last != WIDTH + 2) begin miscompares++; $display("FAIL rr_period: got %0d expected %0d", cyc - last, WIDTH + 2); end
                end
                last = cyc;
                got++;
                if (got == 5) req = '0;
            end
        end
        vectors++;
        if (got != 5) begin miscompares++; $display("FAIL rr_count: got %0d words expected 5", got); end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (gnt !== '0) begin miscompares++; $display("FAIL rr_idle: got gnt=%b expected 0000", gnt); end
    endtask

    task automatic test_stall();
        exp_t       e;
        logic [3:0] w;
        int         n;
        model_word(w);
        sb.push_back('{id: 2'd2, data: w});
        exp_ptr = 3;
        req = 4'b0100; rsp_ready = 1'b0;
        @(negedge clk);
        req = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int c = 0; c <= 10; c++) begin
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data, gnt, lfsr_state} !== {1'b1, e.id, e.data, 4'b0100, m_s}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got valid=%b id=%0d data=%b gnt=%b lfsr=%b expected 1 %0d %b 0100 %b",
                         c, rsp_valid, rsp_id, rsp_data, gnt, lfsr_state, e.id, e.data, m_s);
            end
            if (c < 10) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, gnt} !== '0) begin miscompares++; $display("FAIL stall_accept: got valid=%b gnt=%b expected 0", rsp_valid, gnt); end
    endtask

    task automatic test_seed();
        exp_t       e;
        logic [3:0] w;
        int         n;
        seed_wr = 1'b1; seed = 4'b0000;
        @(negedge clk);
        seed_wr = 1'b0;
        vectors++;
        if ({seed_ack, lfsr_state} !== {1'b1, 4'b0110}) begin miscompares++; $display("FAIL seed_zero: got ack=%b lfsr=%b expected 1 0110", seed_ack, lfsr_state); end
        @(negedge clk);
        vectors++;
        if (seed_ack !== 1'b0) begin miscompares++; $display("FAIL seed_pulse: got ack=%b expected 0", seed_ack); end
        seed_wr = 1'b1; seed = 4'b1001;
        @(negedge clk);
        seed_wr = 1'b0;
        vectors++;
        if ({seed_ack, lfsr_state} !== {1'b1, 4'b1001}) begin miscompares++; $display("FAIL seed_load: got ack=%b lfsr=%b expected 1 1001", seed_ack, lfsr_state); end
        m_s = 4'b1001;
        model_word(w);
        sb.push_back('{id: 2'd0, data: w});
        exp_ptr = 1;
        req = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        req = '0;
        seed_wr = 1'b1; seed = 4'b0101;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (seed_ack !== 1'b0) begin miscompares++; $display("FAIL seed_shift_ack: got ack=%b expected 0", seed_ack); end
        end
        seed_wr = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin
            miscompares++;
            $display("FAIL seed_shift_word: got valid=%b id=%0d data=%b expected 1 %0d %b", rsp_valid, rsp_id, rsp_data, e.id, e.data);
        end
        @(negedge clk);
        vectors++;
        if (lfsr_state !== m_s) begin miscompares++; $display("FAIL seed_shift_lfsr: got %b expected %b", lfsr_state, m_s); end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [3:0] w;
        int         n;
        req = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({gnt, rsp_valid, lfsr_state, rsp_data} !== {4'b0000, 1'b0, 4'b0110, 4'b0000}) begin
            miscompares++;
            $display("FAIL midrst_state: got gnt=%b valid=%b lfsr=%b data=%b expected 0000 0 0110 0000", gnt, rsp_valid, lfsr_state, rsp_data);
        end
        n = 0;
        repeat (8) begin @(negedge clk); if (rsp_valid !== 1'b0) n++; end
        vectors++;
        if (n != 0 || lfsr_state !== 4'b0110) begin miscompares++; $display("FAIL midrst_quiet: got %0d valid cycles lfsr=%b expected 0 0110", n, lfsr_state); end
        m_s = 4'b0110;
        model_word(w);
        sb.push_back('{id: 2'd0, data: w});
        req = 4'b1001;
        @(negedge clk);
        req = '0;
        vectors++;
        if (gnt !== 4'b0001) begin miscompares++; $display("FAIL midrst_ptr: got gnt=%b expected 0001", gnt); end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin
            miscompares++;
            $display("FAIL midrst_word: got valid=%b id=%0d data=%b expected 1 %0d %b", rsp_valid, rsp_id, rsp_data, e.id, e.data);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; rsp_ready = 1'b0; seed_wr = 1'b0; seed = '0;
        m_s = 4'b0110; exp_ptr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_seed();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
